mig_wr_burst_ctrl: RTL

- Downstream of the three-camera image interface wrapper, in the mem_clk domain.
- Consumes the merged write request, address and FIFO level from the wrapper, and returns the write acknowledge and FIFO read enable to it.
- Drives the MIG user (app) interface with fixed-length write bursts: command stream and write-data stream, each with independent backpressure.

---
 rtl/mig_wr_burst_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mig_wr_burst_ctrl.sv
// Fixed-length MIG write-burst controller: grants upstream requests, then streams BURST_LEN commands and data beats.
// Optional MIGWR_STATS_EN adds saturating burst_count/stall_cycles outputs; the default build omits them.
module mig_wr_burst_ctrl #(
  parameter int BURST_LEN = 32,
  parameter int ADDR_INC  = 8,
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 128,
  parameter int CNT_W     = 9
) (
  input  logic              mem_clk,
  input  logic              mem_reset_n,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic [CNT_W-1:0]  fifo_rd_data_count,
  output logic              wdata_rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              busy
`ifdef MIGWR_STATS_EN
  ,
  output logic [31:0]       burst_count,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]     LEN_C = CW'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LEN_L = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] INC_C = ADDR_W'(ADDR_INC);

  typedef enum logic [1:0] {IDLE, GRANT, BURST} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_rst_sync;
  logic [CW-1:0]     r_cmd_cnt;
  logic [CW-1:0]     r_dat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              w_start;
  logic              w_in_burst;
  logic              w_cmd_hs;
  logic              w_dat_hs;
  logic              w_done;

  // Assert asynchronously, release only after two clean mem_clk edges.
  always_ff @(posedge mem_clk or negedge mem_reset_n) begin
    if (!mem_reset_n) r_rst_sync <= 2'b00;
    else              r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_start    = r_rst_sync[1] & init_calib_complete & wr_req &
                      (fifo_rd_data_count >= LEN_L);
  assign w_in_burst = (r_state == BURST);
  assign w_cmd_hs   = app_en & app_rdy;
  assign w_dat_hs   = app_wdf_wren & app_wdf_rdy;
  assign w_done     = (r_cmd_cnt == LEN_C) && (r_dat_cnt == LEN_C);

  always_ff @(posedge mem_clk or negedge mem_reset_n) begin
    if (!mem_reset_n) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    wr_ack = 1'b0;
    busy   = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = GRANT;
      end
      GRANT: begin
        wr_ack = 1'b1;
        w_next = BURST;
      end
      BURST: begin
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      r_addr    <= '0;
      r_cmd_cnt <= '0;
      r_dat_cnt <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      r_addr    <= wr_addr;
      r_cmd_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= r_addr + INC_C;
        r_cmd_cnt <= r_cmd_cnt + 1'b1;
      end
      if (w_dat_hs) r_dat_cnt <= r_dat_cnt + 1'b1;
    end
  end

  assign app_en       = w_in_burst & (r_cmd_cnt < LEN_C);
  assign app_wdf_wren = w_in_burst & (r_dat_cnt < LEN_C);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wdata;
  assign wdata_rd_en  = w_dat_hs;
  assign app_cmd      = 3'b000;
  assign app_addr     = r_addr;

`ifdef MIGWR_STATS_EN
  logic w_stall;
  assign w_stall = w_in_burst & ((app_en & ~app_rdy) | (app_wdf_wren & ~app_wdf_rdy));

  always_ff @(posedge mem_clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      burst_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (wr_ack && (burst_count != 32'hFFFF_FFFF))   burst_count  <= burst_count + 32'd1;
      if (w_stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
